// File: rtl/seg7_pkg.sv
// Shared glyph constants, FSM state type and invalid-value code for the seven-segment readback path.
// Patterns are active-low {a,b,c,d,e,f,g}.
package seg7_pkg;

  localparam logic [6:0] SEG7_0 = 7'b0000001;
  localparam logic [6:0] SEG7_1 = 7'b1001111;
  localparam logic [6:0] SEG7_2 = 7'b0010010;
  localparam logic [6:0] SEG7_3 = 7'b0000110;
  localparam logic [6:0] SEG7_4 = 7'b1001100;
  localparam logic [6:0] SEG7_5 = 7'b0100100;
  localparam logic [6:0] SEG7_6 = 7'b0100000;
  localparam logic [6:0] SEG7_7 = 7'b0001111;
  localparam logic [6:0] SEG7_8 = 7'b0000000;
  localparam logic [6:0] SEG7_9 = 7'b0000100;
  localparam logic [6:0] SEG7_A = 7'b0001000;
  localparam logic [6:0] SEG7_B = 7'b1100000;
  localparam logic [6:0] SEG7_C = 7'b0110001;
  localparam logic [6:0] SEG7_D = 7'b1000010;
  localparam logic [6:0] SEG7_E = 7'b0110000;
  localparam logic [6:0] SEG7_F = 7'b0111000;

  localparam logic [3:0] SEG7_INVALID = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    HOLD
  } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational glyph-to-value decoder; unknown glyphs give SEG7_INVALID with err_o set.
// Build option: define SEG7_DECODE_HEX_EN to also accept the A-F glyphs.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] value_o,
  output logic       err_o
);

  always_comb begin
    value_o = SEG7_INVALID;
    err_o   = 1'b0;
    case (seg_i)
      SEG7_0: value_o = 4'h0;
      SEG7_1: value_o = 4'h1;
      SEG7_2: value_o = 4'h2;
      SEG7_3: value_o = 4'h3;
      SEG7_4: value_o = 4'h4;
      SEG7_5: value_o = 4'h5;
      SEG7_6: value_o = 4'h6;
      SEG7_7: value_o = 4'h7;
      SEG7_8: value_o = 4'h8;
      SEG7_9: value_o = 4'h9;
`ifdef SEG7_DECODE_HEX_EN
      SEG7_A: value_o = 4'hA;
      SEG7_B: value_o = 4'hB;
      SEG7_C: value_o = 4'hC;
      SEG7_D: value_o = 4'hD;
      SEG7_E: value_o = 4'hE;
      SEG7_F: value_o = 4'hF;
`endif
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reads back a multiplexed 7-seg bus: settles each {an,segment} pair, decodes it per digit, pulses per full frame.
// Build option: SEG7_DECODE_HEX_EN (consumed by seg7_pattern_decode) enables A-F glyphs.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              segment,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_strobe,
  output logic                    frame_valid
);

  localparam int              CW       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYCLES - 1);

  logic [NUM_DIGITS+6:0]   sample_d, sample_q;
  logic [CW-1:0]           cnt_d, cnt_q;
  seg7_state_e             state_d, state_q;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   err_q, seen_q, seen_d, sel;
  logic                    strobe_q, valid_q;
  logic                    qual, same, settle_done, capture_en, frame_done;
  logic [3:0]              dec_value;
  logic                    dec_err;

  assign sample_d    = {an, segment};
  assign sel         = ~an;
  assign qual        = $onehot(sel);
  assign same        = (sample_d == sample_q);
  assign settle_done = qual && same && (cnt_q == CNT_LAST);
  assign seen_d      = seen_q | sel;
  assign frame_done  = capture_en && (&seen_d);

  // Counts consecutive identical qualified samples; saturates so a held pattern is captured once.
  assign cnt_d = (!qual || !same) ? '0 :
                 (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  seg7_pattern_decode u_decode (
    .seg_i   (sample_q[6:0]),
    .value_o (dec_value),
    .err_o   (dec_err)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (settle_done)  state_d = CAPTURE;
        else if (qual)    state_d = SETTLE;
      end
      SETTLE: begin
        if (settle_done)          state_d = CAPTURE;
        else if (!qual || !same)  state_d = IDLE;
      end
      CAPTURE: state_d = HOLD;
      HOLD: begin
        // A change landing on the capture edge leaves cnt below saturation; re-settle on it.
        if (!qual)                              state_d = IDLE;
        else if (settle_done)                   state_d = CAPTURE;
        else if (!same || cnt_q != CNT_MAX)     state_d = SETTLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture_en = 1'b0;
    case (state_q)
      IDLE, SETTLE, HOLD: capture_en = settle_done;
      default:            capture_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      err_q    <= '0;
      seen_q   <= '0;
      strobe_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      strobe_q <= frame_done;
      if (capture_en) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (sel[k]) begin
            digits_q[4*k +: 4] <= dec_value;
            err_q[k]           <= dec_err;
          end
        end
        seen_q <= frame_done ? '0 : seen_d;
        if (frame_done) valid_q <= 1'b1;
      end
    end
  end

  assign digits       = digits_q;
  assign digit_err    = err_q;
  assign frame_strobe = strobe_q;
  assign frame_valid  = valid_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (4 digits, 4-cycle settle); expectations follow SEG7_DECODE_HEX_EN.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [6:0]  segment;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        frame_strobe;
  logic        frame_valid;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [6:0] P1    = 7'b1001111;
  localparam logic [6:0] P2    = 7'b0010010;
  localparam logic [6:0] P3    = 7'b0000110;
  localparam logic [6:0] P4    = 7'b1001100;
  localparam logic [6:0] P5    = 7'b0100100;
  localparam logic [6:0] P6    = 7'b0100000;
  localparam logic [6:0] P8    = 7'b0000000;
  localparam logic [6:0] PA    = 7'b0001000;
  localparam logic [6:0] PF    = 7'b0111000;
  localparam logic [6:0] BLANK = 7'b1111111;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.NUM_DIGITS(4), .SETTLE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .an           (an),
    .segment      (segment),
    .digits       (digits),
    .digit_err    (digit_err),
    .frame_strobe (frame_strobe),
    .frame_valid  (frame_valid)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives digit k with glyph s for 6 edges; capture lands on the 5th edge after the change.
  task automatic hold_digit(input int k, input logic [6:0] s, input logic strobe_on_capture);
    an      = ~(4'b0001 << k);
    segment = s;
    for (int c = 1; c <= 6; c++) begin
      tick;
      chk("frame_strobe", 32'(frame_strobe), 32'(strobe_on_capture && (c == 5)));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_digits"}, 32'(digits), 32'h0);
    chk({tag, "_err"},    32'(digit_err), 32'h0);
    chk({tag, "_strobe"}, 32'(frame_strobe), 32'h0);
    chk({tag, "_valid"},  32'(frame_valid), 32'h0);
  endtask

  initial begin
    reset   = 1'b1;
    an      = 4'b1111;
    segment = BLANK;
    repeat (3) tick;
    chk_all_zero("reset");
    reset = 1'b0;
    repeat (2) tick;

    // Single digit: capture exactly 4 edges after the first sample.
    an      = 4'b1110;
    segment = P2;
    repeat (4) tick;
    chk("t1_early_digits", 32'(digits), 32'h0);
    tick;
    chk("t1_digits", 32'(digits), 32'h0002);
    chk("t1_err", 32'(digit_err), 32'h0);
    chk("t1_valid", 32'(frame_valid), 32'h0);
    repeat (2) tick;

    // Full scan 1,2,3,4: frame completes on digit 3.
    hold_digit(0, P1, 1'b0);
    hold_digit(1, P2, 1'b0);
    hold_digit(2, P3, 1'b0);
    hold_digit(3, P4, 1'b1);
    chk("t2_digits", 32'(digits), 32'h4321);
    chk("t2_err", 32'(digit_err), 32'h0);
    chk("t2_valid", 32'(frame_valid), 32'h1);

    // Unstable pattern never settles.
    an = 4'b1101;
    for (int i = 0; i < 6; i++) begin
      segment = (i % 2 == 1) ? P6 : P5;
      tick;
      tick;
      chk("t3_strobe", 32'(frame_strobe), 32'h0);
    end
    chk("t3_digits", 32'(digits), 32'h4321);

    // Blank segments on a selected digit are undecodable.
    hold_digit(2, BLANK, 1'b0);
    chk("t4_digits", 32'(digits), 32'h4F21);
    chk("t4_err", 32'(digit_err), 32'h4);
    chk("t4_valid", 32'(frame_valid), 32'h1);

    // Hex glyphs, then digit 0 completes the second frame.
    hold_digit(3, PA, 1'b0);
`ifdef SEG7_DECODE_HEX_EN
    chk("t5_A_digits", 32'(digits), 32'hAF21);
    chk("t5_A_err", 32'(digit_err), 32'h4);
`else
    chk("t5_A_digits", 32'(digits), 32'hFF21);
    chk("t5_A_err", 32'(digit_err), 32'hC);
`endif
    hold_digit(1, PF, 1'b0);
`ifdef SEG7_DECODE_HEX_EN
    chk("t5_F_digits", 32'(digits), 32'hAFF1);
    chk("t5_F_err", 32'(digit_err), 32'h4);
`else
    chk("t5_F_digits", 32'(digits), 32'hFFF1);
    chk("t5_F_err", 32'(digit_err), 32'hE);
`endif
    hold_digit(0, P8, 1'b1);
`ifdef SEG7_DECODE_HEX_EN
    chk("t5_8_digits", 32'(digits), 32'hAFF8);
`else
    chk("t5_8_digits", 32'(digits), 32'hFFF8);
`endif

    // Reset mid-settle, held through where the capture would have been.
    an      = 4'b1110;
    segment = P3;
    tick;
    tick;
    reset = 1'b1;
    tick;
    chk_all_zero("t6_mid");
    repeat (3) tick;
    chk_all_zero("t6_held");

    // Reset pulse exactly on the capture edge.
    reset = 1'b0;
    repeat (4) tick;
    chk("t6_pre_digits", 32'(digits), 32'h0);
    reset = 1'b1;
    tick;
    chk_all_zero("t6_cap");
    reset = 1'b0;

    // Blanked and multi-low anodes never capture.
    an = 4'b1111;
    repeat (8) tick;
    chk_all_zero("t6_blank");
    an = 4'b1100;
    repeat (8) tick;
    chk_all_zero("t6_multi");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
